// File: rtl/mesi_isc_broad_snoop_pkg.sv
// Shared encodings for the broadcast snoop controller: coherence-bus commands,
// broadcast request types and controller FSM states.
package mesi_isc_broad_snoop_pkg;

    localparam int CBUS_CMD_NOP      = 0;
    localparam int CBUS_CMD_WR_SNOOP = 1;
    localparam int CBUS_CMD_RD_SNOOP = 2;
    localparam int CBUS_CMD_EN_WR    = 3;
    localparam int CBUS_CMD_EN_RD    = 4;

    localparam int BROAD_TYPE_NOP = 0;
    localparam int BROAD_TYPE_WR  = 1;
    localparam int BROAD_TYPE_RD  = 2;

    localparam int NUM_CPUS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SNOOP  = 2'd1,
        ST_ENABLE = 2'd2,
        ST_POP    = 2'd3
    } broad_state_e;

endpackage

// File: rtl/mesi_isc_basic_fifo.sv
// Small synchronous FIFO with registered occupancy; head entry is read
// combinationally and a write while full is dropped.
module mesi_isc_basic_fifo #(
    parameter int DATA_WIDTH     = 43,
    parameter int FIFO_SIZE      = 4,
    parameter int FIFO_SIZE_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic                  rd_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  status_empty_o,
    output logic                  status_full_o
);

    logic [DATA_WIDTH-1:0]     mem_q [FIFO_SIZE];
    logic [FIFO_SIZE_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_SIZE_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_SIZE_LOG2:0]   count_q, count_d;
    logic                      push, pop;

    function automatic logic [FIFO_SIZE_LOG2-1:0] ptr_inc(input logic [FIFO_SIZE_LOG2-1:0] p);
        return (p == FIFO_SIZE_LOG2'(FIFO_SIZE - 1)) ? '0 : p + FIFO_SIZE_LOG2'(1);
    endfunction

    assign status_full_o  = (count_q == (FIFO_SIZE_LOG2 + 1)'(FIFO_SIZE));
    assign status_empty_o = (count_q == '0);
    assign push           = wr_i && !status_full_o;
    assign pop            = rd_i && !status_empty_o;
    assign data_o         = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (FIFO_SIZE_LOG2 + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (FIFO_SIZE_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mesi_isc_broad_snoop.sv
// Broadcast snoop controller: queues broadcast requests, snoops every
// non-initiator CPU, then enables the initiator before retiring the entry.
module mesi_isc_broad_snoop
    import mesi_isc_broad_snoop_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH       = 3,
    parameter int ADDR_WIDTH           = 32,
    parameter int BROAD_TYPE_WIDTH     = 2,
    parameter int BROAD_ID_WIDTH       = 7,
    parameter int BROAD_FIFO_SIZE      = 4,
    parameter int BROAD_FIFO_SIZE_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          broad_fifo_wr_i,
    input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
    input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
    input  logic [1:0]                    broad_cpu_id_i,
    input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
    output logic                          broad_fifo_status_full_o,
    input  logic [3:0]                    cbus_ack_array_i,
    output logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
    output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
    output logic [BROAD_ID_WIDTH-1:0]     active_id_o,
    output logic                          busy_o
);

    localparam int ENTRY_W = ADDR_WIDTH + BROAD_TYPE_WIDTH + 2 + BROAD_ID_WIDTH;

    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(CBUS_CMD_NOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(CBUS_CMD_WR_SNOOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(CBUS_CMD_RD_SNOOP);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(CBUS_CMD_EN_WR);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD);

    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_NOP = BROAD_TYPE_WIDTH'(BROAD_TYPE_NOP);
    localparam logic [BROAD_TYPE_WIDTH-1:0] TYPE_WR  = BROAD_TYPE_WIDTH'(BROAD_TYPE_WR);

    logic [ENTRY_W-1:0]          fifo_wdata, fifo_rdata;
    logic                        fifo_rd, fifo_empty, fifo_full;

    logic [ADDR_WIDTH-1:0]       head_addr;
    logic [BROAD_TYPE_WIDTH-1:0] head_type;
    logic [1:0]                  head_cpu;
    logic [BROAD_ID_WIDTH-1:0]   head_id;

    broad_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_d;
    logic [1:0]                  cpu_q, cpu_d;
    logic [BROAD_ID_WIDTH-1:0]   id_q, id_d;
    logic [3:0]                  done_q, done_d;
    logic [3:0][CBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic [3:0]                  init_mask;
    logic                        in_request;

    function automatic logic [CBUS_CMD_WIDTH-1:0] snoop_cmd(input logic [BROAD_TYPE_WIDTH-1:0] t);
        return (t == TYPE_WR) ? CMD_WR_SNOOP : CMD_RD_SNOOP;
    endfunction

    function automatic logic [CBUS_CMD_WIDTH-1:0] enable_cmd(input logic [BROAD_TYPE_WIDTH-1:0] t);
        return (t == TYPE_WR) ? CMD_EN_WR : CMD_EN_RD;
    endfunction

    assign fifo_wdata = {broad_addr_i, broad_type_i, broad_cpu_id_i, broad_id_i};
    assign {head_addr, head_type, head_cpu, head_id} = fifo_rdata;

    mesi_isc_basic_fifo #(
        .DATA_WIDTH     (ENTRY_W),
        .FIFO_SIZE      (BROAD_FIFO_SIZE),
        .FIFO_SIZE_LOG2 (BROAD_FIFO_SIZE_LOG2)
    ) u_broad_fifo (
        .clk            (clk),
        .rst            (rst),
        .wr_i           (broad_fifo_wr_i),
        .rd_i           (fifo_rd),
        .data_i         (fifo_wdata),
        .data_o         (fifo_rdata),
        .status_empty_o (fifo_empty),
        .status_full_o  (fifo_full)
    );

    assign init_mask  = 4'b0001 << cpu_q;
    assign in_request = (state_q == ST_SNOOP) || (state_q == ST_ENABLE);

    assign broad_fifo_status_full_o = fifo_full;
    assign cbus_cmd_array_o         = cmd_q;
    assign cbus_addr_o              = in_request ? addr_q : '0;
    assign active_id_o              = in_request ? id_q : '0;
    assign busy_o                   = (state_q != ST_IDLE);

    // Command registers are computed from the post-ack done bits so an acked
    // lane falls back to NOP on the very next cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        cpu_d   = cpu_q;
        id_d    = id_q;
        done_d  = done_q;
        cmd_d   = '0;
        fifo_rd = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    addr_d  = head_addr;
                    type_d  = head_type;
                    cpu_d   = head_cpu;
                    id_d    = head_id;
                    state_d = (head_type == TYPE_NOP) ? ST_POP : ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                // Only a lane currently showing a command can be acknowledged.
                for (int i = 0; i < NUM_CPUS; i++) begin
                    if (cbus_ack_array_i[i] && (cmd_q[i] != CMD_NOP)) begin
                        done_d[i] = 1'b1;
                    end
                end
                if ((done_d | init_mask) == 4'hF) begin
                    state_d      = ST_ENABLE;
                    cmd_d[cpu_q] = enable_cmd(type_q);
                end else begin
                    for (int i = 0; i < NUM_CPUS; i++) begin
                        if (!done_d[i] && !init_mask[i]) begin
                            cmd_d[i] = snoop_cmd(type_q);
                        end
                    end
                end
            end
            ST_ENABLE: begin
                if (cbus_ack_array_i[cpu_q]) begin
                    state_d = ST_POP;
                end else begin
                    cmd_d[cpu_q] = enable_cmd(type_q);
                end
            end
            ST_POP: begin
                fifo_rd = 1'b1;
                done_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            cpu_q   <= '0;
            id_q    <= '0;
            done_q  <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            cpu_q   <= cpu_d;
            id_q    <= id_d;
            done_q  <= done_d;
            cmd_q   <= cmd_d;
        end
    end

endmodule

// File: tb/tb_mesi_isc_broad_snoop.sv
// Bench for the broadcast snoop controller: directed protocol scenarios plus
// randomized traffic checked against a transaction-level request queue.
module tb_mesi_isc_broad_snoop;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_WRS = 3'd1;
    localparam logic [2:0] C_RDS = 3'd2;
    localparam logic [2:0] C_ENW = 3'd3;
    localparam logic [2:0] C_ENR = 3'd4;
    localparam logic [1:0] T_NOP = 2'd0;
    localparam logic [1:0] T_WR  = 2'd1;
    localparam logic [1:0] T_RD  = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [6:0]  id;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [1:0]  cpu;
    logic [6:0]  id;
    logic        full;
    logic [3:0]  ack;
    logic [11:0] cmd;
    logic [31:0] caddr;
    logic [6:0]  aid;
    logic        busy;

    int checks = 0;
    int failures = 0;

    ent_t model_q[$];
    ent_t pend_q[$];
    logic [6:0] served_q[$];

    mesi_isc_broad_snoop #(
        .CBUS_CMD_WIDTH(3), .ADDR_WIDTH(32), .BROAD_TYPE_WIDTH(2),
        .BROAD_ID_WIDTH(7), .BROAD_FIFO_SIZE(4), .BROAD_FIFO_SIZE_LOG2(2)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .broad_fifo_wr_i          (wr),
        .broad_addr_i             (addr),
        .broad_type_i             (typ),
        .broad_cpu_id_i           (cpu),
        .broad_id_i               (id),
        .broad_fifo_status_full_o (full),
        .cbus_ack_array_i         (ack),
        .cbus_cmd_array_o         (cmd),
        .cbus_addr_o              (caddr),
        .active_id_o              (aid),
        .busy_o                   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input ent_t e);
        addr = e.addr;
        typ  = e.typ;
        cpu  = e.cpu;
        id   = e.id;
    endtask

    function automatic logic [11:0] lanes_vec(input logic [3:0] mask, input logic [2:0] code);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) if (mask[i]) v[i*3 +: 3] = code;
        return v;
    endfunction

    function automatic logic [2:0] lane(input int i);
        return cmd[i*3 +: 3];
    endfunction

    function automatic logic [2:0] snoop_of(input logic [1:0] t);
        return (t == T_WR) ? C_WRS : C_RDS;
    endfunction

    function automatic logic [2:0] enable_of(input logic [1:0] t);
        return (t == T_WR) ? C_ENW : C_ENR;
    endfunction

    function automatic ent_t rand_entry(input bit allow_nop);
        ent_t e;
        e.addr = $urandom;
        e.typ  = allow_nop ? 2'($urandom_range(0, 2)) : 2'($urandom_range(1, 2));
        e.cpu  = 2'($urandom_range(0, 3));
        e.id   = 7'($urandom);
        return e;
    endfunction

    // Responder: acks commanded lanes at random and checks every command
    // against the oldest outstanding non-NOP request.
    task automatic run_traffic(input int budget, input int ack_pct, input bit spurious);
        logic [3:0]  acked;
        logic [3:0]  mask;
        logic [11:0] exp;
        ent_t        e;
        int          cyc;
        acked = '0;
        cyc   = 0;
        while ((model_q.size() != 0 || pend_q.size() != 0) && cyc < budget) begin
            wr  = 1'b0;
            ack = '0;
            if (pend_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                e = pend_q.pop_front();
                drive_entry(e);
                wr = 1'b1;
                model_q.push_back(e);
            end
            while (model_q.size() != 0 && model_q[0].typ == T_NOP) model_q.delete(0);
            if (cmd !== '0) begin
                checks++;
                if (model_q.size() == 0) begin
                    failures++;
                    $display("FAIL traffic_unexpected_cmd got=%h required=000", cmd);
                end else begin
                    e = model_q[0];
                    if (lane(int'(e.cpu)) !== C_NOP) begin
                        exp = lanes_vec(4'b0001 << e.cpu, enable_of(e.typ));
                        if (cmd !== exp) begin
                            failures++;
                            $display("FAIL traffic_enable got=%h required=%h", cmd, exp);
                        end else if ($urandom_range(1, 100) <= ack_pct) begin
                            ack[e.cpu] = 1'b1;
                            served_q.push_back(e.id);
                            model_q.delete(0);
                            acked = '0;
                        end
                    end else begin
                        mask = ~acked & ~(4'b0001 << e.cpu);
                        exp  = lanes_vec(mask, snoop_of(e.typ));
                        if (cmd !== exp) begin
                            failures++;
                            $display("FAIL traffic_snoop got=%h required=%h", cmd, exp);
                        end else begin
                            for (int i = 0; i < 4; i++) begin
                                if (mask[i] && $urandom_range(1, 100) <= ack_pct) begin
                                    ack[i]   = 1'b1;
                                    acked[i] = 1'b1;
                                end
                            end
                        end
                        if (spurious && $urandom_range(0, 3) == 0) ack[e.cpu] = 1'b1;
                    end
                    checks++;
                    if ({caddr, aid} !== {e.addr, e.id}) begin
                        failures++;
                        $display("FAIL traffic_addr_id got=%h/%h required=%h/%h", caddr, aid, e.addr, e.id);
                    end
                end
            end
            tick;
            cyc++;
        end
        wr  = 1'b0;
        ack = '0;
        checks++;
        if (model_q.size() != 0 || pend_q.size() != 0) begin
            failures++;
            $display("FAIL traffic_timeout outstanding=%0d required=0", model_q.size() + pend_q.size());
        end
        model_q.delete();
        pend_q.delete();
        repeat (6) tick;
        checks++;
        if ({busy, cmd, full} !== '0) begin
            failures++;
            $display("FAIL traffic_idle got busy=%b cmd=%h full=%b required=0/000/0", busy, cmd, full);
        end
    endtask

    task automatic test_reset;
        ent_t e;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd, caddr, aid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h/%h required=0", cmd, caddr, aid);
        end
        checks++;
        if ({busy, full} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got busy=%b full=%b required=0/0", busy, full);
        end
        e = rand_entry(0);
        drive_entry(e);
        wr = 1'b1;
        tick;
        wr  = 1'b0;
        rst = 1'b1;
        repeat (4) tick;
        checks++;
        if ({busy, cmd} !== '0) begin
            failures++;
            $display("FAIL reset_push_ignored got busy=%b cmd=%h required=0/000", busy, cmd);
        end
    endtask

    task automatic test_basic_wr;
        ent_t e;
        e = '{addr: 32'h1000, typ: T_WR, cpu: 2'd2, id: 7'd5};
        drive_entry(e);
        wr = 1'b1;
        tick;
        wr = 1'b0;
        checks++;
        if ({busy, cmd} !== '0) begin
            failures++;
            $display("FAIL basic_n1 got busy=%b cmd=%h required=0/000", busy, cmd);
        end
        tick;
        checks++;
        if ({busy, caddr, aid, cmd} !== {1'b1, 32'h1000, 7'd5, 12'h000}) begin
            failures++;
            $display("FAIL basic_n2 got busy=%b addr=%h id=%h cmd=%h required=1/00001000/05/000", busy, caddr, aid, cmd);
        end
        tick;
        checks++;
        if (cmd !== lanes_vec(4'b1011, C_WRS)) begin
            failures++;
            $display("FAIL basic_snoop got=%h required=%h", cmd, lanes_vec(4'b1011, C_WRS));
        end
        ack = 4'hF;
        tick;
        ack = 4'b0000;
        checks++;
        if (cmd !== lanes_vec(4'b0100, C_ENW)) begin
            failures++;
            $display("FAIL basic_enable got=%h required=%h", cmd, lanes_vec(4'b0100, C_ENW));
        end
        checks++;
        if ({caddr, aid} !== {32'h1000, 7'd5}) begin
            failures++;
            $display("FAIL basic_enable_addr got=%h/%h required=00001000/05", caddr, aid);
        end
        ack = 4'b0100;
        tick;
        ack = 4'b0000;
        checks++;
        if ({busy, cmd, caddr, aid} !== {1'b1, 12'h000, 32'h0, 7'h0}) begin
            failures++;
            $display("FAIL basic_pop got busy=%b cmd=%h addr=%h id=%h required=1/000/0/0", busy, cmd, caddr, aid);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b required=0", busy);
        end
    endtask

    task automatic test_staggered_rd;
        ent_t        e;
        int          ack_at[4];
        logic [3:0]  mask;
        logic [11:0] exp;
        ack_at = '{-1, 1, 6, 4};
        e = rand_entry(0);
        e.typ = T_RD;
        e.cpu = 2'd0;
        drive_entry(e);
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tick;
        tick;
        for (int t = 0; t <= 7; t++) begin
            mask = '0;
            for (int i = 1; i < 4; i++) if (t <= ack_at[i]) mask[i] = 1'b1;
            exp = (t == 7) ? lanes_vec(4'b0001, C_ENR) : lanes_vec(mask, C_RDS);
            checks++;
            if (cmd !== exp) begin
                failures++;
                $display("FAIL stagger_t%0d got=%h required=%h", t, cmd, exp);
            end
            ack = '0;
            for (int i = 0; i < 4; i++) if (ack_at[i] == t) ack[i] = 1'b1;
            if (t == 7) ack[0] = 1'b1;
            tick;
        end
        ack = '0;
        checks++;
        if ({busy, cmd} !== {1'b1, 12'h000}) begin
            failures++;
            $display("FAIL stagger_pop got busy=%b cmd=%h required=1/000", busy, cmd);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stagger_idle got busy=%b required=0", busy);
        end
    endtask

    task automatic test_spurious;
        ent_t        e;
        logic [11:0] exp;
        e = rand_entry(0);
        e.typ = T_WR;
        e.cpu = 2'd1;
        drive_entry(e);
        wr = 1'b1;
        tick;
        wr = 1'b0;
        tick;
        tick;
        for (int t = 0; t <= 5; t++) begin
            if (t == 5)      exp = lanes_vec(4'b0010, C_ENW);
            else if (t == 0) exp = lanes_vec(4'b1101, C_WRS);
            else             exp = lanes_vec(4'b1000, C_WRS);
            checks++;
            if (cmd !== exp) begin
                failures++;
                $display("FAIL spurious_t%0d got=%h required=%h", t, cmd, exp);
            end
            ack = 4'b0010;
            if (t <= 2) ack[0] = 1'b1;
            if (t == 0) ack[2] = 1'b1;
            if (t == 4) ack[3] = 1'b1;
            tick;
        end
        ack = '0;
        checks++;
        if ({busy, cmd} !== {1'b1, 12'h000}) begin
            failures++;
            $display("FAIL spurious_pop got busy=%b cmd=%h required=1/000", busy, cmd);
        end
        tick;
    endtask

    task automatic test_nop_entry;
        ent_t e1, e2;
        e1 = rand_entry(0);
        e1.typ = T_NOP;
        e1.id  = 7'h11;
        e2 = rand_entry(0);
        e2.typ = T_WR;
        e2.id  = 7'h22;
        served_q.delete();
        drive_entry(e1);
        wr = 1'b1;
        tick;
        drive_entry(e2);
        tick;
        wr = 1'b0;
        model_q.push_back(e1);
        model_q.push_back(e2);
        run_traffic(200, 100, 0);
        checks++;
        if (served_q.size() != 1 || served_q[0] !== 7'h22) begin
            failures++;
            $display("FAIL nop_served count=%0d required=1 (id 22)", served_q.size());
        end
    endtask

    task automatic test_full;
        ent_t e;
        served_q.delete();
        for (int k = 1; k <= 5; k++) begin
            e = rand_entry(0);
            e.id = 7'(k);
            drive_entry(e);
            wr = 1'b1;
            if (k <= 4) model_q.push_back(e);
            tick;
            wr = 1'b0;
            checks++;
            if (full !== (k >= 4)) begin
                failures++;
                $display("FAIL full_after_push%0d got=%b required=%b", k, full, (k >= 4));
            end
        end
        repeat (5) tick;
        checks++;
        if (full !== 1'b1) begin
            failures++;
            $display("FAIL full_hold got=%b required=1", full);
        end
        run_traffic(500, 60, 0);
        checks++;
        if (served_q.size() != 4) begin
            failures++;
            $display("FAIL full_served_count got=%0d required=4", served_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (served_q[k] !== 7'(k + 1)) begin
                    failures++;
                    $display("FAIL full_order%0d got=%0d required=%0d", k, served_q[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        ent_t e;
        for (int k = 0; k < 3; k++) begin
            e = rand_entry(0);
            drive_entry(e);
            wr = 1'b1;
            tick;
        end
        wr = 1'b0;
        checks++;
        if (cmd === '0) begin
            failures++;
            $display("FAIL rstmid_snoop_active got=%h required=nonzero", cmd);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, full, cmd, caddr, aid} !== '0) begin
            failures++;
            $display("FAIL rstmid_async got busy=%b full=%b cmd=%h addr=%h id=%h required=0", busy, full, cmd, caddr, aid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            checks++;
            if ({busy, full, cmd} !== '0) begin
                failures++;
                $display("FAIL rstmid_flushed_c%0d got busy=%b full=%b cmd=%h required=0/0/000", t, busy, full, cmd);
            end
            tick;
        end
        served_q.delete();
        e = rand_entry(0);
        e.id = 7'h6A;
        pend_q.push_back(e);
        run_traffic(200, 100, 0);
        checks++;
        if (served_q.size() != 1 || served_q[0] !== 7'h6A) begin
            failures++;
            $display("FAIL rstmid_new_only count=%0d required=1 (id 6a)", served_q.size());
        end
    endtask

    task automatic test_random_traffic;
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) pend_q.push_back(rand_entry(1));
            run_traffic(600, $urandom_range(30, 100), 1);
        end
    endtask

    initial begin
        rst  = 1'b0;
        wr   = 1'b0;
        ack  = '0;
        addr = '0;
        typ  = '0;
        cpu  = '0;
        id   = '0;
        test_reset;
        test_basic_wr;
        test_staggered_rd;
        test_spurious;
        test_nop_entry;
        test_full;
        test_reset_mid;
        test_random_traffic;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
